// File: rtl/leds_pio_pkg.sv
// Shared register map and STATUS field layout for the PWM LED PIO.
package leds_pio_pkg;

    localparam logic [4:0] ADDR_DATA      = 5'd0;
    localparam logic [4:0] ADDR_BLINKMASK = 5'd1;
    localparam logic [4:0] ADDR_BLINKPER  = 5'd2;
    localparam logic [4:0] ADDR_STATUS    = 5'd3;
    localparam logic [4:0] ADDR_SET       = 5'd4;
    localparam logic [4:0] ADDR_CLEAR     = 5'd5;
    localparam logic [4:0] ADDR_TOGGLE    = 5'd6;
    localparam logic [4:0] ADDR_DUTY_BASE = 5'd16;

    localparam int STATUS_PHASE_BIT = 0;
    localparam int STATUS_WIDTH_LSB = 16;
    localparam int STATUS_WIDTH_MSB = 31;

    // Address of the DUTY register belonging to channel n.
    function automatic logic [4:0] duty_addr(input int n);
        return ADDR_DUTY_BASE + 5'(n);
    endfunction

endpackage

// File: rtl/leds_pwm_pio_if.sv
// Avalon-MM slave bus bundle for the PWM LED PIO.
interface leds_pwm_pio_if;
    logic [4:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/leds_pwm_chan.sv
// One LED channel: DUTY register, PWM compare against the shared counter, output flop.
module leds_pwm_chan #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PWM_BITS-1:0] i_pwm_cnt,
    input  logic                i_data,
    input  logic                i_gate,
    input  logic                i_duty_we,
    input  logic [PWM_BITS-1:0] i_duty_wd,
    output logic [PWM_BITS-1:0] o_duty,
    output logic                o_led
);

    logic [PWM_BITS-1:0] r_duty;
    logic                r_led;
    logic                w_pwm_on;

    // Counter tops out at all-ones minus one, so an all-ones duty never turns off.
    assign w_pwm_on = (i_pwm_cnt < r_duty);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_duty <= '1;
            r_led  <= 1'b0;
        end else begin
            if (i_duty_we) begin
                r_duty <= i_duty_wd;
            end
            r_led <= i_data & w_pwm_on & i_gate;
        end
    end

    assign o_duty = r_duty;
    assign o_led  = r_led;

endmodule

// File: rtl/leds_pwm_pio.sv
// Avalon-MM LED PIO with per-channel PWM brightness, set/clear/toggle writes and a blink timer.
module leds_pwm_pio
    import leds_pio_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PWM_BITS = 8,
    parameter int BLINK_W  = 24
) (
    input  logic             clk,
    input  logic             reset,
    leds_pwm_pio_if.slave    bus,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [PWM_BITS-1:0] PWM_LAST  = {{(PWM_BITS-1){1'b1}}, 1'b0};
    localparam logic [BLINK_W-1:0]  BLINK_ONE = BLINK_W'(1);

    logic                w_wr;
    logic [WIDTH-1:0]    w_wd;
    logic [BLINK_W-1:0]  w_wd_per;
    logic                w_unused_wd;
    logic [WIDTH-1:0]    w_gate;
    logic [31:0]         w_rdata;
    logic [PWM_BITS-1:0] w_duty [WIDTH];

    logic [WIDTH-1:0]    r_data;
    logic [WIDTH-1:0]    r_mask;
    logic [BLINK_W-1:0]  r_blink_per;
    logic [BLINK_W-1:0]  r_blink_cnt;
    logic                r_phase;
    logic [PWM_BITS-1:0] r_pwm_cnt;

    assign w_wr        = bus.chipselect & ~bus.write_n;
    assign w_wd        = bus.writedata[WIDTH-1:0];
    assign w_wd_per    = bus.writedata[BLINK_W-1:0];
    assign w_unused_wd = ^bus.writedata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= '0;
            r_mask <= '0;
        end else if (w_wr) begin
            case (bus.address)
                ADDR_DATA:      r_data <= w_wd;
                ADDR_BLINKMASK: r_mask <= w_wd;
                ADDR_SET:       r_data <= r_data | w_wd;
                ADDR_CLEAR:     r_data <= r_data & ~w_wd;
                ADDR_TOGGLE:    r_data <= r_data ^ w_wd;
                default: ;
            endcase
        end
    end

    // A BLINKPER write restarts the half-period with the LEDs in the lit phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_blink_per <= '0;
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (w_wr && (bus.address == ADDR_BLINKPER)) begin
            r_blink_per <= w_wd_per;
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (r_blink_per == '0) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (r_blink_cnt == (r_blink_per - BLINK_ONE)) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + BLINK_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pwm_cnt <= '0;
        end else if (r_pwm_cnt == PWM_LAST) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
        end
    end

    assign w_gate = ~r_mask | {WIDTH{r_phase}};

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_chan
            leds_pwm_chan #(
                .PWM_BITS (PWM_BITS)
            ) u_chan (
                .clk       (clk),
                .reset     (reset),
                .i_pwm_cnt (r_pwm_cnt),
                .i_data    (r_data[gi]),
                .i_gate    (w_gate[gi]),
                .i_duty_we (w_wr && (bus.address == duty_addr(gi))),
                .i_duty_wd (bus.writedata[PWM_BITS-1:0]),
                .o_duty    (w_duty[gi]),
                .o_led     (out_port[gi])
            );
        end
    endgenerate

    // Zero-wait-state read: decoded from address alone, write-only and unmapped slots read 0.
    always_comb begin
        w_rdata = '0;
        case (bus.address)
            ADDR_DATA:      w_rdata[WIDTH-1:0]   = r_data;
            ADDR_BLINKMASK: w_rdata[WIDTH-1:0]   = r_mask;
            ADDR_BLINKPER:  w_rdata[BLINK_W-1:0] = r_blink_per;
            ADDR_STATUS: begin
                w_rdata[STATUS_PHASE_BIT]                  = r_phase;
                w_rdata[STATUS_WIDTH_MSB:STATUS_WIDTH_LSB] = 16'(WIDTH);
            end
            default: begin
                for (int n = 0; n < WIDTH; n++) begin
                    if (bus.address == duty_addr(n)) begin
                        w_rdata[PWM_BITS-1:0] = w_duty[n];
                    end
                end
            end
        endcase
    end

    assign bus.readdata = w_rdata;

endmodule

// File: tb/tb_leds_pwm_pio.sv
// Scoreboard bench for leds_pwm_pio: stimulus queues expectations, a negedge monitor checks them.
module tb_leds_pwm_pio;

    localparam int WIDTH    = 8;
    localparam int PWM_BITS = 8;
    localparam int BLINK_W  = 24;
    localparam logic [31:0] STAT_BASE = 32'h0008_0000;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] out_port;

    leds_pwm_pio_if bus ();

    leds_pwm_pio #(
        .WIDTH    (WIDTH),
        .PWM_BITS (PWM_BITS),
        .BLINK_W  (BLINK_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .out_port (out_port)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum {K_RD, K_OUT, K_CNT} kind_e;
    typedef struct {
        kind_e       kind;
        int          due;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cnt_from = -1;
    int   cnt_to = -1;
    int   hi_cnt = 0;
    bit   drain_timeout = 1'b0;

    task automatic expect_at(input kind_e k, input int due, input logic [31:0] e, input string nm);
        chk_t c;
        c.kind = k;
        c.due  = due;
        c.exp  = e;
        c.name = nm;
        sb.push_back(c);
    endtask

    // Monitor: counts PWM high cycles in the armed window and retires due expectations.
    initial begin : monitor
        chk_t        keep[$];
        logic [31:0] act;
        bit          timeout_seen;
        timeout_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (cyc == cnt_from) hi_cnt = 0;
            if (cyc >= cnt_from && cyc < cnt_to) hi_cnt += int'(out_port[2]);
            keep = {};
            foreach (sb[i]) begin
                if (sb[i].due > cyc) begin
                    keep.push_back(sb[i]);
                end else begin
                    case (sb[i].kind)
                        K_RD:    act = bus.readdata;
                        K_OUT:   act = 32'(out_port);
                        default: act = 32'(hi_cnt);
                    endcase
                    checks++;
                    if (sb[i].due < cyc) begin
                        errors++;
                        $display("FAIL %s: missed check cycle %0d, now %0d", sb[i].name, sb[i].due, cyc);
                    end else if (act !== sb[i].exp) begin
                        errors++;
                        $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", sb[i].name, act, sb[i].exp, cyc);
                    end else begin
                        $display("ok   %s: 0x%08h (cycle %0d)", sb[i].name, act, cyc);
                    end
                end
            end
            sb = keep;
            if (drain_timeout && !timeout_seen) begin
                timeout_seen = 1'b1;
                checks++;
                errors++;
                $display("FAIL drain_timeout: pending=%0d required=0", sb.size());
            end
        end
    end

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(posedge clk); #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] e, input string nm);
        @(posedge clk); #1;
        bus.address = a;
        expect_at(K_RD, cyc, e, nm);
    endtask

    task automatic pwm_window(input logic [31:0] duty, input int exp_hi, input string nm);
        int w;
        wr(5'd18, duty);
        w = cyc;
        cnt_from = w + 2;
        cnt_to   = w + 2 + 255;
        expect_at(K_CNT, cnt_to, 32'(exp_hi), nm);
        repeat (258) @(posedge clk);
        #1;
    endtask

    initial begin : stim
        int w;
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        expect_at(K_OUT, cyc, 32'h0, "rst_out");
        rd(5'd0, 32'h0, "rst_data");
        rd(5'd1, 32'h0, "rst_mask");
        rd(5'd2, 32'h0, "rst_per");
        rd(5'd3, STAT_BASE | 32'h1, "rst_status");
        rd(5'd16, 32'hFF, "rst_duty0");
        rd(5'd23, 32'hFF, "rst_duty7");

        // DATA write: read during the write cycle sees the old value, output follows later
        @(posedge clk); #1;
        bus.address    = 5'd0;
        bus.writedata  = 32'hFFFF_FFA5;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        expect_at(K_RD, cyc, 32'h0, "wr_reads_old");
        @(posedge clk); #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        w = cyc;
        expect_at(K_OUT, w, 32'h0, "out_before_update");
        expect_at(K_OUT, w + 2, 32'hA5, "out_a5");
        rd(5'd0, 32'hA5, "rd_data_a5");

        // Atomic set / clear / toggle
        wr(5'd0, 32'hF0);
        wr(5'd4, 32'h0F);
        rd(5'd0, 32'hFF, "set_0f");
        wr(5'd5, 32'h30);
        rd(5'd0, 32'hCF, "clear_30");
        wr(5'd6, 32'h81);
        rd(5'd0, 32'h4E, "toggle_81");
        rd(5'd4, 32'h0, "rd_set_zero");
        rd(5'd5, 32'h0, "rd_clear_zero");
        rd(5'd6, 32'h0, "rd_toggle_zero");
        expect_at(K_OUT, cyc + 1, 32'h4E, "out_4e");

        // PWM duty on channel 2
        wr(5'd0, 32'h04);
        pwm_window(32'd64, 64, "duty64_hi");
        rd(5'd18, 32'h40, "rd_duty2");
        pwm_window(32'd0, 0, "duty0_hi");
        pwm_window(32'd255, 255, "duty255_hi");

        // Blink on channel 0, half-period 10
        wr(5'd0, 32'h01);
        wr(5'd1, 32'h01);
        wr(5'd2, 32'd10);
        w = cyc;
        bus.address = 5'd3;
        expect_at(K_OUT, w + 5,  32'h1, "blink_on_a");
        expect_at(K_RD,  w + 9,  STAT_BASE | 32'h1, "phase_hi_a");
        expect_at(K_RD,  w + 10, STAT_BASE, "phase_lo_a");
        expect_at(K_OUT, w + 10, 32'h1, "blink_on_b");
        expect_at(K_OUT, w + 11, 32'h0, "blink_off_a");
        expect_at(K_RD,  w + 19, STAT_BASE, "phase_lo_b");
        expect_at(K_OUT, w + 20, 32'h0, "blink_off_b");
        expect_at(K_RD,  w + 20, STAT_BASE | 32'h1, "phase_hi_b");
        expect_at(K_OUT, w + 21, 32'h1, "blink_on_c");
        repeat (22) @(posedge clk);
        #1;
        rd(5'd1, 32'h01, "rd_mask");
        rd(5'd2, 32'd10, "rd_per");
        wr(5'd2, 32'd0);
        w = cyc;
        bus.address = 5'd3;
        expect_at(K_OUT, w + 2,  32'h1, "steady_a");
        expect_at(K_RD,  w + 11, STAT_BASE | 32'h1, "steady_phase");
        expect_at(K_OUT, w + 12, 32'h1, "steady_b");
        repeat (13) @(posedge clk);
        #1;

        // Reset mid-blink, coinciding with a DATA write
        wr(5'd19, 32'h12);
        rd(5'd19, 32'h12, "rd_duty3");
        wr(5'd2, 32'd10);
        w = cyc;
        expect_at(K_OUT, w + 5, 32'h1, "pre_rst_out");
        repeat (5) @(posedge clk);
        #1;
        bus.address    = 5'd0;
        bus.writedata  = 32'hFF;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        reset          = 1'b1;
        @(posedge clk); #1;
        reset          = 1'b0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        expect_at(K_OUT, cyc, 32'h0, "rst_mid_out");
        expect_at(K_RD, cyc, 32'h0, "rst_mid_data");
        rd(5'd1, 32'h0, "rst_mid_mask");
        rd(5'd2, 32'h0, "rst_mid_per");
        rd(5'd3, STAT_BASE | 32'h1, "rst_mid_status");
        rd(5'd19, 32'hFF, "rst_mid_duty3");
        expect_at(K_OUT, cyc + 3, 32'h0, "rst_mid_out_hold");

        // Unmapped addresses
        wr(5'd24, 32'h33);
        wr(5'd7, 32'h33);
        rd(5'd24, 32'h0, "rd_addr24");
        rd(5'd7, 32'h0, "rd_addr7");
        rd(5'd0, 32'h0, "unmapped_data");
        rd(5'd16, 32'hFF, "unmapped_duty0");
        rd(5'd1, 32'h0, "unmapped_mask");
        rd(5'd3, STAT_BASE | 32'h1, "status_width");
        expect_at(K_OUT, cyc + 1, 32'h0, "unmapped_out");

        for (int i = 0; i < 1000 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) drain_timeout = 1'b1;
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
